// File: rtl/uart_config_mc.sv
// Shadow/active configuration registers for NUM_CH UART channels on the shared config bus.
// Each channel's shadow set is copied to its active set only on an edge where that UART is idle.
module uart_config_mc #(
    parameter int                    NUM_CH            = 4,
    parameter int                    WIDTH_CONFIG_ADDR = 8,
    parameter int                    WIDTH_CONFIG_DATA = 16,
    parameter int                    BASE_TAG          = 'h5,
    parameter int                    BAUD_W            = 16,
    parameter logic [BAUD_W-1:0]     BAUD_DIV_RST      = 16'd434
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
    input  logic                         c_valid,
    output logic                         c_ready,
    output logic                         c_ack,
    output logic                         cfg_err,
    input  logic [NUM_CH-1:0]            ch_busy,
    output logic [2*NUM_CH-1:0]          parity_cfg,
    output logic [NUM_CH-1:0]            stop_cfg,
    output logic [2*NUM_CH-1:0]          dlen_cfg,
    output logic [BAUD_W*NUM_CH-1:0]     baud_div,
    output logic [NUM_CH-1:0]            cfg_update
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAG_W = WIDTH_CONFIG_ADDR - CH_W - 2;

    // Bus handshake: a transfer happens on an edge where c_valid & c_ready and the
    // tag matches. c_ready only drops for a claimed access whose channel already
    // holds a pending update and is still busy.

    logic [TAG_W-1:0]  addr_tag;
    logic [CH_W-1:0]   addr_ch;
    logic [1:0]        addr_sel;
    logic [BAUD_W-1:0] wr_baud;
    logic              tag_hit;
    logic [NUM_CH-1:0] ch_sel;
    logic              xfer;
    logic              wr_legal;
    logic              wr_en;

    logic [NUM_CH-1:0][1:0]        act_par_q,  act_par_d;
    logic [NUM_CH-1:0]             act_stop_q, act_stop_d;
    logic [NUM_CH-1:0][1:0]        act_dlen_q, act_dlen_d;
    logic [NUM_CH-1:0][BAUD_W-1:0] act_baud_q, act_baud_d;
    logic [NUM_CH-1:0][1:0]        sh_par_q,   sh_par_d;
    logic [NUM_CH-1:0]             sh_stop_q,  sh_stop_d;
    logic [NUM_CH-1:0][1:0]        sh_dlen_q,  sh_dlen_d;
    logic [NUM_CH-1:0][BAUD_W-1:0] sh_baud_q,  sh_baud_d;
    logic [NUM_CH-1:0]             pending_q,  pending_d;
    logic [NUM_CH-1:0]             cfg_update_q, cfg_update_d;
    logic                          c_ack_q, c_ack_d;
    logic                          cfg_err_q, cfg_err_d;

    assign addr_tag = c_addr[WIDTH_CONFIG_ADDR-1:CH_W+2];
    assign addr_ch  = c_addr[CH_W+1:2];
    assign addr_sel = c_addr[1:0];
    assign wr_baud  = c_data[BAUD_W-1:0];
    assign tag_hit  = (addr_tag == TAG_W'(BASE_TAG));

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (addr_ch == CH_W'(i));
        end
    end

    assign c_ready = ~(tag_hit & (|(ch_sel & pending_q & ch_busy)));
    assign xfer    = c_valid & c_ready & tag_hit;

    always_comb begin
        wr_legal = 1'b1;
        case (addr_sel)
            2'b00:   wr_legal = (c_data[1:0] != 2'b01);
            2'b11:   wr_legal = (wr_baud != '0);
            default: wr_legal = 1'b1;
        endcase
    end

    assign wr_en     = xfer & wr_legal;
    assign c_ack_d   = xfer;
    assign cfg_err_d = xfer & ~wr_legal;

    // Apply is evaluated before the write so it copies the pre-edge shadow;
    // a same-edge write then re-arms pending for the next idle edge.
    always_comb begin
        act_par_d    = act_par_q;
        act_stop_d   = act_stop_q;
        act_dlen_d   = act_dlen_q;
        act_baud_d   = act_baud_q;
        sh_par_d     = sh_par_q;
        sh_stop_d    = sh_stop_q;
        sh_dlen_d    = sh_dlen_q;
        sh_baud_d    = sh_baud_q;
        pending_d    = pending_q;
        cfg_update_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pending_q[i] && !ch_busy[i]) begin
                act_par_d[i]    = sh_par_q[i];
                act_stop_d[i]   = sh_stop_q[i];
                act_dlen_d[i]   = sh_dlen_q[i];
                act_baud_d[i]   = sh_baud_q[i];
                pending_d[i]    = 1'b0;
                cfg_update_d[i] = 1'b1;
            end
            if (wr_en && ch_sel[i]) begin
                case (addr_sel)
                    2'b00:   sh_par_d[i]  = c_data[1:0];
                    2'b01:   sh_stop_d[i] = c_data[0];
                    2'b10:   sh_dlen_d[i] = c_data[1:0];
                    default: sh_baud_d[i] = wr_baud;
                endcase
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_par_q    <= '0;
            act_stop_q   <= '0;
            act_dlen_q   <= {NUM_CH{2'b11}};
            act_baud_q   <= {NUM_CH{BAUD_DIV_RST}};
            sh_par_q     <= '0;
            sh_stop_q    <= '0;
            sh_dlen_q    <= {NUM_CH{2'b11}};
            sh_baud_q    <= {NUM_CH{BAUD_DIV_RST}};
            pending_q    <= '0;
            cfg_update_q <= '0;
            c_ack_q      <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            act_par_q    <= act_par_d;
            act_stop_q   <= act_stop_d;
            act_dlen_q   <= act_dlen_d;
            act_baud_q   <= act_baud_d;
            sh_par_q     <= sh_par_d;
            sh_stop_q    <= sh_stop_d;
            sh_dlen_q    <= sh_dlen_d;
            sh_baud_q    <= sh_baud_d;
            pending_q    <= pending_d;
            cfg_update_q <= cfg_update_d;
            c_ack_q      <= c_ack_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign parity_cfg = act_par_q;
    assign stop_cfg   = act_stop_q;
    assign dlen_cfg   = act_dlen_q;
    assign baud_div   = act_baud_q;
    assign cfg_update = cfg_update_q;
    assign c_ack      = c_ack_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_config_mc.sv
// Bench for uart_config_mc: directed scenarios plus random traffic against a
// per-channel shadow/active record model.
module tb_uart_config_mc;

    localparam int NUM_CH = 4;
    localparam int BAUD_W = 16;
    localparam int VW     = 2 + NUM_CH + 2*NUM_CH + NUM_CH + 2*NUM_CH + BAUD_W*NUM_CH;

    logic                     clk;
    logic                     rst;
    logic [7:0]               c_addr;
    logic [15:0]              c_data;
    logic                     c_valid;
    logic                     c_ready;
    logic                     c_ack;
    logic                     cfg_err;
    logic [NUM_CH-1:0]        ch_busy;
    logic [2*NUM_CH-1:0]      parity_cfg;
    logic [NUM_CH-1:0]        stop_cfg;
    logic [2*NUM_CH-1:0]      dlen_cfg;
    logic [BAUD_W*NUM_CH-1:0] baud_div;
    logic [NUM_CH-1:0]        cfg_update;

    uart_config_mc #(
        .NUM_CH(NUM_CH), .WIDTH_CONFIG_ADDR(8), .WIDTH_CONFIG_DATA(16),
        .BASE_TAG('h5), .BAUD_W(BAUD_W), .BAUD_DIV_RST(16'd434)
    ) dut (
        .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
        .c_ready(c_ready), .c_ack(c_ack), .cfg_err(cfg_err), .ch_busy(ch_busy),
        .parity_cfg(parity_cfg), .stop_cfg(stop_cfg), .dlen_cfg(dlen_cfg),
        .baud_div(baud_div), .cfg_update(cfg_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  par;
        logic        stop;
        logic [1:0]  dlen;
        logic [15:0] baud;
    } cfg_t;

    cfg_t              m_act [NUM_CH];
    cfg_t              m_sh  [NUM_CH];
    logic              m_pend[NUM_CH];
    logic [NUM_CH-1:0] m_upd;
    logic              m_ack;
    logic              m_err;
    logic [VW-1:0]     exp_q[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic          r_o, r_e;
    logic [VW-1:0] p_o, p_e;

    function automatic logic [VW-1:0] pack_exp();
        logic [2*NUM_CH-1:0]      p;
        logic [NUM_CH-1:0]        s;
        logic [2*NUM_CH-1:0]      dl;
        logic [BAUD_W*NUM_CH-1:0] bd;
        for (int i = 0; i < NUM_CH; i++) begin
            p[2*i +: 2]        = m_act[i].par;
            s[i]               = m_act[i].stop;
            dl[2*i +: 2]       = m_act[i].dlen;
            bd[BAUD_W*i +: BAUD_W] = m_act[i].baud;
        end
        return {m_ack, m_err, m_upd, p, s, dl, bd};
    endfunction

    function automatic logic [VW-1:0] pack_obs();
        return {c_ack, cfg_err, cfg_update, parity_cfg, stop_cfg, dlen_cfg, baud_div};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_act[i]  = '{par: 2'b00, stop: 1'b0, dlen: 2'b11, baud: 16'd434};
            m_sh[i]   = m_act[i];
            m_pend[i] = 1'b0;
        end
        m_upd = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the model: idle channels publish their pending shadow,
    // then an accepted legal write lands in the shadow and re-arms pending.
    task automatic model_edge(input logic v, input logic [7:0] a, input logic [15:0] d,
                              input logic [NUM_CH-1:0] b, output logic rdy);
        int         ch;
        logic [1:0] sel;
        logic       claimed, xfer, ok;
        ch      = int'(a[3:2]);
        sel     = a[1:0];
        claimed = (a[7:4] == 4'h5);
        rdy     = !(claimed && m_pend[ch] && b[ch]);
        xfer    = v && claimed && rdy;
        ok      = !((sel == 2'b00 && d[1:0] == 2'b01) || (sel == 2'b11 && d == 16'd0));
        m_upd   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_pend[i] && !b[i]) begin
                m_act[i]  = m_sh[i];
                m_pend[i] = 1'b0;
                m_upd[i]  = 1'b1;
            end
        end
        if (xfer && ok) begin
            case (sel)
                2'b00:   m_sh[ch].par  = d[1:0];
                2'b01:   m_sh[ch].stop = d[0];
                2'b10:   m_sh[ch].dlen = d[1:0];
                default: m_sh[ch].baud = d;
            endcase
            m_pend[ch] = 1'b1;
        end
        m_ack = xfer;
        m_err = xfer && !ok;
        exp_q.push_back(pack_exp());
    endtask

    // Called at posedge+1; returns pre-edge ready (observed/expected) and post-edge status.
    task automatic step(input logic v, input logic [7:0] a, input logic [15:0] d,
                        input logic [NUM_CH-1:0] b, output logic rdy_o, output logic rdy_e,
                        output logic [VW-1:0] post_o);
        c_valid = v;
        c_addr  = a;
        c_data  = d;
        ch_busy = b;
        #1;
        rdy_o = c_ready;
        model_edge(v, a, d, b, rdy_e);
        @(posedge clk);
        #1;
        post_o = pack_obs();
    endtask

    task automatic test_reset();
        rst = 1'b1; c_valid = 1'b0; c_addr = '0; c_data = '0; ch_busy = '0;
        model_reset();
        #3;
        n_checks++;
        if ({parity_cfg, stop_cfg, dlen_cfg} !== {8'h00, 4'h0, 8'hFF} || baud_div !== {4{16'd434}})
        begin
            n_fail++;
            $display("FAIL reset_values: got par=%h stop=%h dlen=%h baud=%h", parity_cfg, stop_cfg, dlen_cfg, baud_div);
        end
        n_checks++;
        if ({c_ready, c_ack, cfg_err, cfg_update} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_pulses: got ready=%b ack=%b err=%b upd=%b", c_ready, c_ack, cfg_err, cfg_update);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 16'h0, '0, r_o, r_e, p_o);
            p_e = exp_q.pop_front();
            n_checks++;
            if (r_o !== r_e || p_o !== p_e || cfg_update !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle: ready %b want %b status %h want %h", r_o, r_e, p_o, p_e);
            end
        end
    endtask

    task automatic test_idle_write();
        step(1'b1, 8'h58, 16'h0003, 4'b0000, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (r_o !== r_e || p_o !== p_e || c_ack !== 1'b1 || parity_cfg[5:4] !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_write_ack: ack=%b status %h want %h", c_ack, p_o, p_e);
        end
        step(1'b0, 8'h00, 16'h0, 4'b0000, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (p_o !== p_e || parity_cfg !== 8'b0011_0000 || cfg_update !== 4'b0100) begin
            n_fail++;
            $display("FAIL idle_write_apply: par=%b upd=%b want par=00110000 upd=0100", parity_cfg, cfg_update);
        end
    endtask

    task automatic test_deferred();
        step(1'b1, 8'h57, 16'd217, 4'b0010, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (r_o !== r_e || p_o !== p_e || c_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL deferred_accept: ready %b want %b status %h want %h", r_o, r_e, p_o, p_e);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'h57, 16'd300, 4'b0010, r_o, r_e, p_o);
            p_e = exp_q.pop_front();
            n_checks++;
            if (r_o !== 1'b0 || p_o !== p_e || c_ack !== 1'b0 || baud_div[31:16] !== 16'd434) begin
                n_fail++;
                $display("FAIL deferred_stall: ready=%b ack=%b baud1=%0d want ready=0 ack=0 baud1=434", r_o, c_ack, baud_div[31:16]);
            end
        end
        step(1'b1, 8'h57, 16'd300, 4'b0000, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (r_o !== 1'b1 || p_o !== p_e || baud_div[31:16] !== 16'd217 || cfg_update !== 4'b0010 || c_ack !== 1'b1)
        begin
            n_fail++;
            $display("FAIL deferred_apply: ready=%b baud1=%0d upd=%b ack=%b want 1/217/0010/1", r_o, baud_div[31:16], cfg_update, c_ack);
        end
        step(1'b0, 8'h00, 16'h0, 4'b0000, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (p_o !== p_e || baud_div[31:16] !== 16'd300 || cfg_update !== 4'b0010) begin
            n_fail++;
            $display("FAIL deferred_second: baud1=%0d upd=%b want 300/0010", baud_div[31:16], cfg_update);
        end
    endtask

    task automatic test_illegal();
        logic [7:0]  a_tab[2];
        a_tab[0] = 8'h50;
        a_tab[1] = 8'h5F;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, a_tab[k], (k == 0) ? 16'h0001 : 16'h0000, 4'b0000, r_o, r_e, p_o);
            p_e = exp_q.pop_front();
            n_checks++;
            if (p_o !== p_e || {c_ack, cfg_err} !== 2'b11) begin
                n_fail++;
                $display("FAIL illegal_err_%0d: ack=%b err=%b status %h want %h", k, c_ack, cfg_err, p_o, p_e);
            end
        end
        step(1'b0, 8'h00, 16'h0, 4'b0000, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (p_o !== p_e || cfg_update !== 4'b0000 || parity_cfg[1:0] !== 2'b00 || baud_div[63:48] !== 16'd434)
        begin
            n_fail++;
            $display("FAIL illegal_no_apply: upd=%b par0=%b baud3=%0d want 0000/00/434", cfg_update, parity_cfg[1:0], baud_div[63:48]);
        end
    endtask

    task automatic test_unclaimed_cross();
        step(1'b1, 8'h40, 16'h0003, 4'b1111, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (r_o !== 1'b1 || p_o !== p_e || c_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL unclaimed: ready=%b ack=%b want 1/0", r_o, c_ack);
        end
        step(1'b1, 8'h51, 16'h0001, 4'b0001, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (p_o !== p_e || c_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL cross_ch0_accept: status %h want %h", p_o, p_e);
        end
        step(1'b1, 8'h5E, 16'h0002, 4'b0001, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (r_o !== 1'b1 || p_o !== p_e || c_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL cross_ch3_accept: ready=%b ack=%b want 1/1", r_o, c_ack);
        end
        step(1'b1, 8'h51, 16'h0000, 4'b0001, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (r_o !== 1'b0 || p_o !== p_e || dlen_cfg[7:6] !== 2'b10 || cfg_update !== 4'b1000 || stop_cfg[0] !== 1'b0)
        begin
            n_fail++;
            $display("FAIL cross_ch3_apply: ready=%b dlen3=%b upd=%b stop0=%b want 0/10/1000/0", r_o, dlen_cfg[7:6], cfg_update, stop_cfg[0]);
        end
        step(1'b0, 8'h00, 16'h0, 4'b0000, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (p_o !== p_e || stop_cfg[0] !== 1'b1 || cfg_update !== 4'b0001) begin
            n_fail++;
            $display("FAIL cross_ch0_apply: stop0=%b upd=%b want 1/0001", stop_cfg[0], cfg_update);
        end
    endtask

    task automatic test_reset_mid_pending();
        step(1'b1, 8'h59, 16'h0001, 4'b0100, r_o, r_e, p_o);
        p_e = exp_q.pop_front();
        n_checks++;
        if (p_o !== p_e || c_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_accept: status %h want %h", p_o, p_e);
        end
        c_valid = 1'b0;
        rst     = 1'b1;
        #2;
        model_reset();
        n_checks++;
        if (stop_cfg !== 4'b0000 || cfg_update !== 4'b0000 || c_ack !== 1'b0 || baud_div !== {4{16'd434}}) begin
            n_fail++;
            $display("FAIL midrst_async: stop=%b upd=%b ack=%b want 0000/0000/0", stop_cfg, cfg_update, c_ack);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 8'h00, 16'h0, 4'b0000, r_o, r_e, p_o);
            p_e = exp_q.pop_front();
            n_checks++;
            if (p_o !== p_e || cfg_update !== 4'b0000 || stop_cfg[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_apply: upd=%b stop2=%b want 0000/0", cfg_update, stop_cfg[2]);
            end
        end
    endtask

    task automatic test_random();
        logic              v;
        logic [7:0]        a;
        logic [15:0]       d;
        logic [NUM_CH-1:0] b;
        int                r;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 3) != 0);
            a[7:4] = ($urandom_range(0, 7) == 0) ? 4'h4 : 4'h5;
            a[3:0] = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 3);
            d = (r == 0) ? 16'h0000 : (r == 1) ? 16'h0001 : 16'($urandom_range(0, 65535));
            for (int i = 0; i < NUM_CH; i++) b[i] = ($urandom_range(0, 2) == 0);
            step(v, a, d, b, r_o, r_e, p_o);
            p_e = exp_q.pop_front();
            n_checks++;
            if (r_o !== r_e || p_o !== p_e) begin
                n_fail++;
                $display("FAIL random_%0d: ready %b want %b status %h want %h", k, r_o, r_e, p_o, p_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_write();
        test_deferred();
        test_illegal();
        test_unclaimed_cross();
        test_reset_mid_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_config_mc.md
Name: uart_config_mc

Overview:
- Multi-channel, parametrised UART configuration register block on the shared configuration bus (address, data, valid, ready).
- Holds parity, stop-bit, data-length and baud-divisor settings for NUM_CH UART channels.
- Writes land in a per-channel shadow set. The shadow is copied to the active set only while that channel's UART is idle, so a frame in flight never sees a configuration change.
- Adds write acknowledge and illegal-value reporting.

Parameters:
- NUM_CH, 4, number of UART channels; power of two, 1..8. CH_W = max(1, clog2(NUM_CH)).
- WIDTH_CONFIG_ADDR, 8, configuration address width; must be >= CH_W+2+1.
- WIDTH_CONFIG_DATA, 16, configuration data width; must be >= BAUD_W.
- BASE_TAG, 'h5, value that c_addr[WIDTH_CONFIG_ADDR-1:CH_W+2] must equal for this block to claim an access.
- BAUD_W, 16, baud divisor width.
- BAUD_DIV_RST, 16'd434, reset baud divisor (115200 baud at 50 MHz).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- c_addr  in  WIDTH_CONFIG_ADDR  config address: {tag, channel[CH_W-1:0], reg_sel[1:0]}.
- c_data  in  WIDTH_CONFIG_DATA  config write data.
- c_valid  in  1  config write request.
- c_ready  out  1  block can accept the current request; transfer occurs on c_valid & c_ready.
- c_ack  out  1  one-cycle pulse, cycle after a claimed transfer.
- cfg_err  out  1  one-cycle pulse with c_ack when the written value was illegal and discarded.
- ch_busy  in  NUM_CH  per-channel UART busy (frame in progress).
- parity_cfg  out  2*NUM_CH  active parity per channel: 00 none, 10 even, 11 odd.
- stop_cfg  out  NUM_CH  active stop bits: 0 one, 1 two.
- dlen_cfg  out  2*NUM_CH  active data length: 00=5, 01=6, 10=7, 11=8 bits.
- baud_div  out  BAUD_W*NUM_CH  active baud divisor per channel.
- cfg_update  out  NUM_CH  one-cycle pulse, cycle in which that channel's active set changed.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Asserting rst mid-operation immediately forces the reset state; shadow writes and pending updates are discarded.
- Reset state, active and shadow sets alike, all channels:
  - parity 00, stop 0, dlen 11, baud_div BAUD_DIV_RST.
  - pending 0; c_ack, cfg_err and cfg_update all 0.
- Claim: an access is claimed when the tag field equals BASE_TAG. Unclaimed accesses are ignored and c_ready stays 1 (not this block's stall).
- Register select, applied to shadow[ch] with ch = c_addr[CH_W+1:2]:
  - 00 parity <= c_data[1:0]; value 01 is illegal.
  - 01 stop <= c_data[0].
  - 10 dlen <= c_data[1:0].
  - 11 baud_div <= c_data[BAUD_W-1:0]; value 0 is illegal.
- Illegal value: the transfer still completes, shadow is unchanged, pending is unchanged, and cfg_err pulses with c_ack.
- Accept: a legal claimed transfer at edge N writes the addressed shadow field and sets pending[ch]. c_ack (and cfg_err if illegal) is high during cycle N+1.
- c_ready is combinational. It is 0 only when the access is claimed, pending[ch]=1 and ch_busy[ch]=1; otherwise it is 1.
- Apply, per channel, independently:
  - At any edge with pending[i]=1 and ch_busy[i]=0: active[i] <= shadow[i] (all four fields) and pending[i] <= 0.
  - cfg_update[i] is high the cycle after that edge, while the new values are visible.
  - Minimum latency from accept edge to active change is 1 cycle.
- Simultaneous apply and write, same channel, same edge (pending=1, busy=0, c_ready=1):
  - Apply copies the pre-edge shadow.
  - The write merges into the shadow and pending stays 1.
  - The new field applies at the next idle edge.
- Multiple writes while a channel is busy and not pending: the first write is accepted and sets pending. Further writes to that channel stall until busy drops and the apply occurs.
- Channels never interact; writes to channel j are unaffected by ch_busy[i], i != j.
- Output packing: channel i occupies parity_cfg[2i+1:2i], stop_cfg[i], dlen_cfg[2i+1:2i] and baud_div[BAUD_W*(i+1)-1:BAUD_W*i].

Test Plan:
- Reset then idle: rst pulse, no traffic -> every channel reads parity 00, stop 0, dlen 11, baud_div 434; c_ready=1; no c_ack, cfg_err or cfg_update pulses.
- Idle write: ch_busy=0, write addr {5,ch2,00} data 2'b11 at edge N -> c_ack high in cycle N+1, parity_cfg[5:4]=11 and cfg_update[2] high in cycle N+2; other channels unchanged.
- Deferred apply: ch_busy[1]=1, write baud 217 to ch1 -> accepted, baud_div ch1 stays 434. A second write to ch1 sees c_ready=0 until ch_busy[1] falls; at that fall the active divisor becomes 217 with a cfg_update[1] pulse, then the second write is accepted.
- Illegal values: parity write 2'b01 to ch0, and baud 0 to ch3 -> each gets c_ack with cfg_err; no shadow change, no pending, no cfg_update.
- Unclaimed and cross-channel: tag 4 with c_valid -> no c_ack, c_ready=1. ch0 busy and pending while writing ch3 -> ch3 accepted and applied normally.
- Reset mid-pending: ch2 busy with a pending stop=1 write, assert rst -> stop_cfg[2]=0 after release; no cfg_update when ch_busy[2] later drops.
